invader_formation_ctrl: RTL and testbench
=========================================

// Module: invader_formation_ctrl
// PURPOSE
// Frame-paced scheduler that positions the invader formation sprite block.
// - Counts display frames and steps the formation horizontally once per period.
// - At a screen edge it drops the formation by one row and reverses direction.
// - Drives sprite_x/sprite_y of the invader sprite instances.
// - Reports the landed (game-over) condition to the game logic.
// PARAMETERS
// SCREEN_CORDW     16   width of screen coordinates
// H_RES            640  visible horizontal resolution
// FORM_W           352  formation width in pixels (post-scale)
// START_X          32   reset/restart x of formation left edge
// START_Y          40   reset/restart y of formation top edge
// STEP_X           8    horizontal step in pixels
// STEP_Y           16   vertical drop in pixels
// FRAMES_PER_STEP  30   initial step period in frames
// MIN_PERIOD       4    floor of step period after speedups
// FLOOR_Y          400  form_y >= FLOOR_Y => landed
// PORTS
// clk_pix   in   1             pixel clock
// rst       in   1             async reset, active-high
// frame     in   1             1-cycle pulse at start of each frame (display_480p)
// en        in   1             1 = frames advance the step counter
// speedup   in   1             1-cycle pulse: period -= 1, saturating at MIN_PERIOD
// restart   in   1             1-cycle pulse: return to start state
// form_x    out  SCREEN_CORDW  formation left edge x
// form_y    out  SCREEN_CORDW  formation top edge y
// dir       out  1             1 = moving right, 0 = moving left
// step      out  1             1-cycle pulse when form_x or form_y changes
// landed    out  1             sticky; set when formation reaches FLOOR_Y
// BEHAVIOUR
// Reset and clocking:
// - One clock, clk_pix; rst is asynchronous, active-high.
// - Reset values: form_x=START_X, form_y=START_Y, dir=1, step=0, landed=0.
// - Reset values (internal): period=FRAMES_PER_STEP, fcnt=0, state=WAIT.
// - All outputs are registered.
// States: WAIT, EVAL, MOVE, DROP, LANDED.
// WAIT:
// - On frame && en: if fcnt==period-1 then fcnt<=0 and go to EVAL.
// - Otherwise fcnt<=fcnt+1.
// - en=0 freezes fcnt.
// EVAL:
// - Edge test uses SCREEN_CORDW+1 bit arithmetic.
// - dir=1 and form_x+STEP_X+FORM_W > H_RES: go to DROP.
// - dir=0 and form_x < STEP_X: go to DROP.
// - Otherwise go to MOVE.
// MOVE:
// - form_x +/- STEP_X according to dir; step=1; go to WAIT.
// DROP:
// - form_y += STEP_Y; dir toggles; step=1.
// - If form_y+STEP_Y >= FLOOR_Y: landed<=1 and go to LANDED, else go to WAIT.
// LANDED:
// - Position frozen; ignores frame and en; exit only via restart or rst.
// Timing and concurrent events:
// - step is registered and asserts 2 cycles after the triggering frame pulse.
// - EVAL/MOVE/DROP always complete even if en drops mid-sequence.
// - A frame pulse arriving during EVAL/MOVE/DROP is not counted (display frames are far apart).
// - speedup: period saturates at MIN_PERIOD.
// - speedup on the same cycle as frame: compare uses the old period; the new period applies from the next cycle.
// - restart takes priority over all events in any state, including mid-EVAL/MOVE/DROP.
// - restart: next cycle, every register equals its reset value, including period; step=0.
// TESTING
// - rst pulse, en=1, 30 frames -> form_x 32->40 after 30th frame; step high exactly 2 cycles after it.
// - 32 steps right -> form_x=288; next trigger -> DROP: form_y=56, dir=0, form_x stays 288.
// - Run left to form_x=0; next trigger -> form_y +16, dir=1, no x underflow.
// - 23 drops from y=40 -> form_y=408, landed=1; further frames hold position; restart -> 32/40, landed=0.
// - 30 speedup pulses -> period floors at 4 (steps every 4 frames); speedup+frame same cycle uses old period.
// - en=0 for 100 frames -> no step; restart and rst asserted mid-DROP -> reset values, no step pulse.

Source files
------------

// File: rtl/invader_formation_ctrl.sv
// Invader formation scheduler: steps the formation sideways once every `period`
// frames, and at a screen edge it drops one row and reverses direction.
module invader_formation_ctrl #(
    parameter int SCREEN_CORDW    = 16,
    parameter int H_RES           = 640,
    parameter int FORM_W          = 352,
    parameter int START_X         = 32,
    parameter int START_Y         = 40,
    parameter int STEP_X          = 8,
    parameter int STEP_Y          = 16,
    parameter int FRAMES_PER_STEP = 30,
    parameter int MIN_PERIOD      = 4,
    parameter int FLOOR_Y         = 400
) (
    input  logic                    i_clk_pix,
    input  logic                    i_rst,
    input  logic                    i_frame,
    input  logic                    i_en,
    input  logic                    i_speedup,
    input  logic                    i_restart,
    output logic [SCREEN_CORDW-1:0] o_form_x,
    output logic [SCREEN_CORDW-1:0] o_form_y,
    output logic                    o_dir,
    output logic                    o_step,
    output logic                    o_landed
);

    localparam int PW = $clog2(FRAMES_PER_STEP + 1);
    localparam int EW = SCREEN_CORDW + 1;

    localparam logic [SCREEN_CORDW-1:0] START_X_C = SCREEN_CORDW'(START_X);
    localparam logic [SCREEN_CORDW-1:0] START_Y_C = SCREEN_CORDW'(START_Y);
    localparam logic [SCREEN_CORDW-1:0] STEP_X_C  = SCREEN_CORDW'(STEP_X);
    localparam logic [SCREEN_CORDW-1:0] STEP_Y_C  = SCREEN_CORDW'(STEP_Y);
    localparam logic [EW-1:0]           RIGHT_SPAN = EW'(STEP_X + FORM_W);
    localparam logic [EW-1:0]           H_RES_E    = EW'(H_RES);
    localparam logic [EW-1:0]           STEP_X_E   = EW'(STEP_X);
    localparam logic [EW-1:0]           STEP_Y_E   = EW'(STEP_Y);
    localparam logic [EW-1:0]           FLOOR_E    = EW'(FLOOR_Y);
    localparam logic [PW-1:0]           PERIOD_INIT = PW'(FRAMES_PER_STEP);
    localparam logic [PW-1:0]           PERIOD_MIN  = PW'(MIN_PERIOD);

    typedef enum logic [2:0] {
        S_WAIT,
        S_EVAL,
        S_MOVE,
        S_DROP,
        S_LANDED
    } state_t;

    state_t                  r_state;
    logic [PW-1:0]           r_fcnt;
    logic [PW-1:0]           r_period;
    logic [SCREEN_CORDW-1:0] r_form_x;
    logic [SCREEN_CORDW-1:0] r_form_y;
    logic                    r_dir;
    logic                    r_step;
    logic                    r_landed;

    state_t                  w_state_nxt;
    logic [PW-1:0]           w_fcnt_nxt;
    logic [PW-1:0]           w_period_nxt;
    logic [SCREEN_CORDW-1:0] w_form_x_nxt;
    logic [SCREEN_CORDW-1:0] w_form_y_nxt;
    logic                    w_dir_nxt;
    logic                    w_step_nxt;
    logic                    w_landed_nxt;

    // Edge tests use one extra bit so the sums cannot wrap.
    logic [EW-1:0] w_right_sum;
    logic [EW-1:0] w_drop_sum;
    logic [PW-1:0] w_period_m1;

    assign w_right_sum = {1'b0, r_form_x} + RIGHT_SPAN;
    assign w_drop_sum  = {1'b0, r_form_y} + STEP_Y_E;
    assign w_period_m1 = r_period - PW'(1);

    always_ff @(posedge i_clk_pix or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_WAIT;
            r_fcnt   <= '0;
            r_period <= PERIOD_INIT;
            r_form_x <= START_X_C;
            r_form_y <= START_Y_C;
            r_dir    <= 1'b1;
            r_step   <= 1'b0;
            r_landed <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_fcnt   <= w_fcnt_nxt;
            r_period <= w_period_nxt;
            r_form_x <= w_form_x_nxt;
            r_form_y <= w_form_y_nxt;
            r_dir    <= w_dir_nxt;
            r_step   <= w_step_nxt;
            r_landed <= w_landed_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_fcnt_nxt   = r_fcnt;
        w_period_nxt = r_period;
        w_form_x_nxt = r_form_x;
        w_form_y_nxt = r_form_y;
        w_dir_nxt    = r_dir;
        w_step_nxt   = 1'b0;
        w_landed_nxt = r_landed;

        // The frame compare below sees the old period; the decrement lands next cycle.
        if (i_speedup && (r_period > PERIOD_MIN)) begin
            w_period_nxt = w_period_m1;
        end

        case (r_state)
            S_WAIT: begin
                if (i_frame && i_en) begin
                    if (r_fcnt == w_period_m1) begin
                        w_fcnt_nxt  = '0;
                        w_state_nxt = S_EVAL;
                    end else begin
                        w_fcnt_nxt = r_fcnt + PW'(1);
                    end
                end
            end
            S_EVAL: begin
                if (r_dir && (w_right_sum > H_RES_E)) begin
                    w_state_nxt = S_DROP;
                end else if (!r_dir && ({1'b0, r_form_x} < STEP_X_E)) begin
                    w_state_nxt = S_DROP;
                end else begin
                    w_state_nxt = S_MOVE;
                end
            end
            S_MOVE: begin
                w_form_x_nxt = r_dir ? (r_form_x + STEP_X_C) : (r_form_x - STEP_X_C);
                w_step_nxt   = 1'b1;
                w_state_nxt  = S_WAIT;
            end
            S_DROP: begin
                w_form_y_nxt = r_form_y + STEP_Y_C;
                w_dir_nxt    = ~r_dir;
                w_step_nxt   = 1'b1;
                if (w_drop_sum >= FLOOR_E) begin
                    w_landed_nxt = 1'b1;
                    w_state_nxt  = S_LANDED;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_LANDED: begin
                w_state_nxt = S_LANDED;
            end
            default: begin
                w_state_nxt = S_WAIT;
            end
        endcase

        // Restart overrides everything, whatever state the sequence is in.
        if (i_restart) begin
            w_state_nxt  = S_WAIT;
            w_fcnt_nxt   = '0;
            w_period_nxt = PERIOD_INIT;
            w_form_x_nxt = START_X_C;
            w_form_y_nxt = START_Y_C;
            w_dir_nxt    = 1'b1;
            w_step_nxt   = 1'b0;
            w_landed_nxt = 1'b0;
        end
    end

    assign o_form_x = r_form_x;
    assign o_form_y = r_form_y;
    assign o_dir    = r_dir;
    assign o_step   = r_step;
    assign o_landed = r_landed;

endmodule

// File: tb/tb_invader_formation_ctrl.sv
// Directed bench for invader_formation_ctrl: stepping, edges, landing,
// speedup, enable gating and restart/reset in the middle of a drop.
module tb_invader_formation_ctrl;

    logic        i_clk_pix = 1'b0;
    logic        i_rst     = 1'b1;
    logic        i_frame   = 1'b0;
    logic        i_en      = 1'b1;
    logic        i_speedup = 1'b0;
    logic        i_restart = 1'b0;
    logic [15:0] o_form_x;
    logic [15:0] o_form_y;
    logic        o_dir;
    logic        o_step;
    logic        o_landed;

    int compared   = 0;
    int mismatched = 0;
    int stepCount  = 0;
    int base;

    invader_formation_ctrl dut (
        .i_clk_pix (i_clk_pix),
        .i_rst     (i_rst),
        .i_frame   (i_frame),
        .i_en      (i_en),
        .i_speedup (i_speedup),
        .i_restart (i_restart),
        .o_form_x  (o_form_x),
        .o_form_y  (o_form_y),
        .o_dir     (o_dir),
        .o_step    (o_step),
        .o_landed  (o_landed)
    );

    always #5 i_clk_pix = ~i_clk_pix;

    // Step pulses are tallied just after each rising edge.
    always @(posedge i_clk_pix) begin
        #1;
        if (o_step === 1'b1) stepCount++;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    // One frame pulse followed by idle cycles so any step sequence completes.
    task automatic send_frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk_pix); i_frame = 1'b1;
            @(negedge i_clk_pix); i_frame = 1'b0;
            repeat (3) @(negedge i_clk_pix);
        end
    endtask

    task automatic send_speedups(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk_pix); i_speedup = 1'b1;
            @(negedge i_clk_pix); i_speedup = 1'b0;
        end
    endtask

    task automatic do_restart();
        @(negedge i_clk_pix); i_restart = 1'b1;
        @(negedge i_clk_pix); i_restart = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge i_clk_pix);
        compared++; if (o_form_x !== 16'd32) begin mismatched++; $display("[TB] FAIL reset_x got %0d want 32", o_form_x); end
        compared++; if (o_form_y !== 16'd40) begin mismatched++; $display("[TB] FAIL reset_y got %0d want 40", o_form_y); end
        compared++; if (o_dir !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_dir got %b want 1", o_dir); end
        compared++; if (o_step !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_step got %b want 0", o_step); end
        compared++; if (o_landed !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_landed got %b want 0", o_landed); end
        i_rst = 1'b0;
        @(negedge i_clk_pix);
    endtask

    task automatic test_first_step();
        base = stepCount;
        send_frames(29);
        compared++; if (stepCount != base) begin mismatched++; $display("[TB] FAIL first_29_frames steps got %0d want 0", stepCount - base); end
        compared++; if (o_form_x !== 16'd32) begin mismatched++; $display("[TB] FAIL first_29_x got %0d want 32", o_form_x); end
        @(negedge i_clk_pix); i_frame = 1'b1;
        @(negedge i_clk_pix); i_frame = 1'b0;
        compared++; if (o_step !== 1'b0) begin mismatched++; $display("[TB] FAIL step_latency_0 got %b want 0", o_step); end
        @(negedge i_clk_pix);
        compared++; if (o_step !== 1'b0) begin mismatched++; $display("[TB] FAIL step_latency_1 got %b want 0", o_step); end
        @(negedge i_clk_pix);
        compared++; if (o_step !== 1'b1) begin mismatched++; $display("[TB] FAIL step_latency_2 got %b want 1", o_step); end
        compared++; if (o_form_x !== 16'd40) begin mismatched++; $display("[TB] FAIL first_step_x got %0d want 40", o_form_x); end
        @(negedge i_clk_pix);
        compared++; if (o_step !== 1'b0) begin mismatched++; $display("[TB] FAIL step_width got %b want 0", o_step); end
        repeat (2) @(negedge i_clk_pix);
    endtask

    task automatic test_speedup_floor();
        send_speedups(30);
        base = stepCount;
        send_frames(3);
        compared++; if (stepCount != base) begin mismatched++; $display("[TB] FAIL floor_3_frames steps got %0d want 0", stepCount - base); end
        send_frames(1);
        compared++; if (stepCount != base + 1) begin mismatched++; $display("[TB] FAIL floor_4th_frame steps got %0d want 1", stepCount - base); end
        compared++; if (o_form_x !== 16'd48) begin mismatched++; $display("[TB] FAIL floor_x got %0d want 48", o_form_x); end
        send_frames(4);
        compared++; if (o_form_x !== 16'd56) begin mismatched++; $display("[TB] FAIL floor_x2 got %0d want 56", o_form_x); end
    endtask

    task automatic test_speedup_same_cycle();
        do_restart();
        compared++; if (o_form_x !== 16'd32) begin mismatched++; $display("[TB] FAIL restart_x got %0d want 32", o_form_x); end
        base = stepCount;
        send_frames(29);
        compared++; if (stepCount != base) begin mismatched++; $display("[TB] FAIL restart_period steps got %0d want 0", stepCount - base); end
        @(negedge i_clk_pix); i_frame = 1'b1; i_speedup = 1'b1;
        @(negedge i_clk_pix); i_frame = 1'b0; i_speedup = 1'b0;
        repeat (3) @(negedge i_clk_pix);
        compared++; if (stepCount != base + 1) begin mismatched++; $display("[TB] FAIL same_cycle_old_period steps got %0d want 1", stepCount - base); end
        compared++; if (o_form_x !== 16'd40) begin mismatched++; $display("[TB] FAIL same_cycle_x got %0d want 40", o_form_x); end
        send_frames(28);
        compared++; if (stepCount != base + 1) begin mismatched++; $display("[TB] FAIL new_period_28 steps got %0d want 1", stepCount - base); end
        send_frames(1);
        compared++; if (stepCount != base + 2) begin mismatched++; $display("[TB] FAIL new_period_29 steps got %0d want 2", stepCount - base); end
        compared++; if (o_form_x !== 16'd48) begin mismatched++; $display("[TB] FAIL new_period_x got %0d want 48", o_form_x); end
    endtask

    task automatic test_right_edge();
        do_restart();
        send_speedups(30);
        base = stepCount;
        send_frames(128);
        compared++; if (stepCount != base + 32) begin mismatched++; $display("[TB] FAIL right_steps got %0d want 32", stepCount - base); end
        compared++; if (o_form_x !== 16'd288) begin mismatched++; $display("[TB] FAIL right_x got %0d want 288", o_form_x); end
        compared++; if (o_form_y !== 16'd40) begin mismatched++; $display("[TB] FAIL right_y got %0d want 40", o_form_y); end
        send_frames(4);
        compared++; if (o_form_y !== 16'd56) begin mismatched++; $display("[TB] FAIL right_drop_y got %0d want 56", o_form_y); end
        compared++; if (o_dir !== 1'b0) begin mismatched++; $display("[TB] FAIL right_drop_dir got %b want 0", o_dir); end
        compared++; if (o_form_x !== 16'd288) begin mismatched++; $display("[TB] FAIL right_drop_x got %0d want 288", o_form_x); end
        compared++; if (stepCount != base + 33) begin mismatched++; $display("[TB] FAIL right_drop_step got %0d want 33", stepCount - base); end
    endtask

    task automatic test_left_edge();
        send_frames(144);
        compared++; if (o_form_x !== 16'd0) begin mismatched++; $display("[TB] FAIL left_x got %0d want 0", o_form_x); end
        compared++; if (o_form_y !== 16'd56) begin mismatched++; $display("[TB] FAIL left_y got %0d want 56", o_form_y); end
        send_frames(4);
        compared++; if (o_form_y !== 16'd72) begin mismatched++; $display("[TB] FAIL left_drop_y got %0d want 72", o_form_y); end
        compared++; if (o_dir !== 1'b1) begin mismatched++; $display("[TB] FAIL left_drop_dir got %b want 1", o_dir); end
        compared++; if (o_form_x !== 16'd0) begin mismatched++; $display("[TB] FAIL left_drop_x got %0d want 0", o_form_x); end
    endtask

    task automatic test_landed();
        send_frames((21 * 37 - 1) * 4);
        compared++; if (o_form_y !== 16'd392) begin mismatched++; $display("[TB] FAIL prelanding_y got %0d want 392", o_form_y); end
        compared++; if (o_form_x !== 16'd288) begin mismatched++; $display("[TB] FAIL prelanding_x got %0d want 288", o_form_x); end
        compared++; if (o_landed !== 1'b0) begin mismatched++; $display("[TB] FAIL prelanding_landed got %b want 0", o_landed); end
        send_frames(4);
        compared++; if (o_form_y !== 16'd408) begin mismatched++; $display("[TB] FAIL landing_y got %0d want 408", o_form_y); end
        compared++; if (o_landed !== 1'b1) begin mismatched++; $display("[TB] FAIL landing_flag got %b want 1", o_landed); end
        compared++; if (o_dir !== 1'b0) begin mismatched++; $display("[TB] FAIL landing_dir got %b want 0", o_dir); end
        base = stepCount;
        send_frames(40);
        compared++; if (stepCount != base) begin mismatched++; $display("[TB] FAIL landed_frozen steps got %0d want 0", stepCount - base); end
        compared++; if (o_form_x !== 16'd288 || o_form_y !== 16'd408) begin mismatched++; $display("[TB] FAIL landed_hold got %0d/%0d want 288/408", o_form_x, o_form_y); end
        compared++; if (o_landed !== 1'b1) begin mismatched++; $display("[TB] FAIL landed_sticky got %b want 1", o_landed); end
        do_restart();
        compared++; if (o_form_x !== 16'd32 || o_form_y !== 16'd40) begin mismatched++; $display("[TB] FAIL landed_restart_pos got %0d/%0d want 32/40", o_form_x, o_form_y); end
        compared++; if (o_landed !== 1'b0 || o_dir !== 1'b1) begin mismatched++; $display("[TB] FAIL landed_restart_flags got landed=%b dir=%b want 0/1", o_landed, o_dir); end
    endtask

    task automatic test_enable();
        base = stepCount;
        i_en = 1'b0;
        send_frames(100);
        i_en = 1'b1;
        compared++; if (stepCount != base) begin mismatched++; $display("[TB] FAIL en_off steps got %0d want 0", stepCount - base); end
        compared++; if (o_form_x !== 16'd32) begin mismatched++; $display("[TB] FAIL en_off_x got %0d want 32", o_form_x); end
        send_frames(29);
        compared++; if (stepCount != base) begin mismatched++; $display("[TB] FAIL en_frozen_count steps got %0d want 0", stepCount - base); end
        send_frames(1);
        compared++; if (o_form_x !== 16'd40) begin mismatched++; $display("[TB] FAIL en_resume_x got %0d want 40", o_form_x); end
    endtask

    task automatic test_restart_mid_drop();
        do_restart();
        send_speedups(30);
        send_frames(128);
        base = stepCount;
        @(negedge i_clk_pix); i_frame = 1'b1;
        @(negedge i_clk_pix); i_frame = 1'b0;
        @(negedge i_clk_pix); i_restart = 1'b1;
        @(negedge i_clk_pix); i_restart = 1'b0;
        compared++; if (o_form_x !== 16'd32 || o_form_y !== 16'd40) begin mismatched++; $display("[TB] FAIL mid_drop_restart_pos got %0d/%0d want 32/40", o_form_x, o_form_y); end
        compared++; if (o_dir !== 1'b1 || o_step !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_drop_restart_flags got dir=%b step=%b want 1/0", o_dir, o_step); end
        repeat (3) @(negedge i_clk_pix);
        compared++; if (stepCount != base) begin mismatched++; $display("[TB] FAIL mid_drop_restart steps got %0d want 0", stepCount - base); end
        send_frames(4);
        compared++; if (stepCount != base) begin mismatched++; $display("[TB] FAIL mid_drop_period_reset steps got %0d want 0", stepCount - base); end
    endtask

    task automatic test_rst_mid_drop();
        do_restart();
        send_speedups(30);
        send_frames(128);
        base = stepCount;
        @(negedge i_clk_pix); i_frame = 1'b1;
        @(negedge i_clk_pix); i_frame = 1'b0;
        @(negedge i_clk_pix); i_rst = 1'b1;
        #1;
        compared++; if (o_form_x !== 16'd32 || o_form_y !== 16'd40) begin mismatched++; $display("[TB] FAIL mid_drop_rst_pos got %0d/%0d want 32/40", o_form_x, o_form_y); end
        compared++; if (o_dir !== 1'b1 || o_landed !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_drop_rst_flags got dir=%b landed=%b want 1/0", o_dir, o_landed); end
        @(negedge i_clk_pix); i_rst = 1'b0;
        repeat (3) @(negedge i_clk_pix);
        compared++; if (stepCount != base) begin mismatched++; $display("[TB] FAIL mid_drop_rst steps got %0d want 0", stepCount - base); end
        compared++; if (o_form_y !== 16'd40) begin mismatched++; $display("[TB] FAIL mid_drop_rst_hold_y got %0d want 40", o_form_y); end
    endtask

    initial begin
        test_reset();
        test_first_step();
        test_speedup_floor();
        test_speedup_same_cycle();
        test_right_edge();
        test_left_edge();
        test_landed();
        test_enable();
        test_restart_mid_drop();
        test_rst_mid_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
